// File: rtl/vga_sync_generator.sv
// Vertical line counter and registered sync/active/coordinate outputs for a VGA raster,
// driven by an upstream horizontal pixel counter that shares the same pixel enable.
module vga_sync_generator #(
  parameter int unsigned H_VISIBLE   = 1024,
  parameter int unsigned H_FRONT     = 24,
  parameter int unsigned H_SYNC      = 136,
  parameter int unsigned H_TOTAL     = 1328,
  parameter int unsigned V_VISIBLE   = 768,
  parameter int unsigned V_FRONT     = 3,
  parameter int unsigned V_SYNC      = 6,
  parameter int unsigned V_TOTAL     = 806,
  parameter logic        SYNC_ACTIVE = 1'b0
) (
  input  logic        control_clock,
  input  logic        control_reset_n,
  input  logic        sync_enable,
  input  logic [10:0] h_count,
  output logic        hsync,
  output logic        vsync,
  output logic        video_active,
  output logic [10:0] pixel_x,
  output logic [9:0]  pixel_y,
  output logic        line_end,
  output logic        frame_start
);

  localparam logic [10:0] HActEnd    = 11'(H_VISIBLE);
  localparam logic [10:0] HSyncStart = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] HSyncEnd   = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] HLast      = 11'(H_TOTAL - 1);
  localparam logic [9:0]  VActEnd    = 10'(V_VISIBLE);
  localparam logic [9:0]  VSyncStart = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0]  VSyncEnd   = 10'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [9:0]  VLast      = 10'(V_TOTAL - 1);

  logic [9:0]  v_count_q, v_count_d;
  logic        hsync_q, vsync_q, video_active_q, line_end_q, frame_start_q;
  logic [10:0] pixel_x_q;
  logic [9:0]  pixel_y_q;

  logic h_active, h_sync, h_last, v_active, v_sync, active;

  // Out-of-range h_count (>= H_TOTAL) falls outside every region below, so it reads as blanking.
  always_comb begin
    h_active = (h_count < HActEnd);
    h_sync   = (h_count >= HSyncStart) && (h_count < HSyncEnd);
    h_last   = (h_count == HLast);
    v_active = (v_count_q < VActEnd);
    v_sync   = (v_count_q >= VSyncStart) && (v_count_q < VSyncEnd);
    active   = h_active && v_active;
  end

  always_comb begin
    v_count_d = v_count_q;
    if (h_last) begin
      v_count_d = (v_count_q == VLast) ? 10'd0 : v_count_q + 10'd1;
    end
  end

  always_ff @(posedge control_clock) begin
    if (!control_reset_n) begin
      v_count_q      <= 10'd0;
      hsync_q        <= ~SYNC_ACTIVE;
      vsync_q        <= ~SYNC_ACTIVE;
      video_active_q <= 1'b0;
      pixel_x_q      <= 11'd0;
      pixel_y_q      <= 10'd0;
      line_end_q     <= 1'b0;
      frame_start_q  <= 1'b0;
    end else if (sync_enable) begin
      v_count_q      <= v_count_d;
      hsync_q        <= h_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      // vsync uses the pre-advance line so the last line's sync state is not skipped
      vsync_q        <= v_sync ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      video_active_q <= active;
      pixel_x_q      <= active ? h_count : 11'd0;
      pixel_y_q      <= active ? v_count_q : 10'd0;
      line_end_q     <= h_last;
      frame_start_q  <= (h_count == 11'd0) && (v_count_q == 10'd0);
    end else begin
      // Strobes must not repeat while the pixel enable is stalled.
      line_end_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end
  end

  assign hsync        = hsync_q;
  assign vsync        = vsync_q;
  assign video_active = video_active_q;
  assign pixel_x      = pixel_x_q;
  assign pixel_y      = pixel_y_q;
  assign line_end     = line_end_q;
  assign frame_start  = frame_start_q;

endmodule

// File: tb/tb_vga_sync_generator.sv
// Directed bench for vga_sync_generator: reset, horizontal sweep, frame walk, stall,
// mid-frame reset and out-of-range h_count, all against hand-derived expectations.
module tb_vga_sync_generator;

  logic        control_clock = 1'b0;
  logic        control_reset_n;
  logic        sync_enable;
  logic [10:0] h_count;
  logic        hsync, vsync, video_active, line_end, frame_start;
  logic [10:0] pixel_x;
  logic [9:0]  pixel_y;

  int n_cmp = 0;
  int n_bad = 0;
  int v_model = 0;
  int fs_count;
  int vline;

  vga_sync_generator dut (
    .control_clock  (control_clock),
    .control_reset_n(control_reset_n),
    .sync_enable    (sync_enable),
    .h_count        (h_count),
    .hsync          (hsync),
    .vsync          (vsync),
    .video_active   (video_active),
    .pixel_x        (pixel_x),
    .pixel_y        (pixel_y),
    .line_end       (line_end),
    .frame_start    (frame_start)
  );

  always #5 control_clock = ~control_clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (v_model=%0d)", tag, got, exp, v_model);
    end
  endtask

  // Drive one sample, take the edge, and land 1 time unit after it.
  task automatic tick(input int h, input logic en);
    h_count     = 11'(h);
    sync_enable = en;
    @(posedge control_clock);
    #1;
    if (!control_reset_n) v_model = 0;
    else if (en && h == 1327) v_model = (v_model == 805) ? 0 : v_model + 1;
  endtask

  function automatic logic exp_vsync(input int v);
    return (v >= 771 && v <= 776) ? 1'b0 : 1'b1;
  endfunction

  initial begin
    control_reset_n = 1'b0;
    sync_enable     = 1'b1;
    h_count         = 11'd500;

    // Reset held 3 cycles with enable high.
    for (int i = 0; i < 3; i++) tick(500, 1'b1);
    check("rst_hsync", hsync, 1);
    check("rst_vsync", vsync, 1);
    check("rst_active", video_active, 0);
    check("rst_px", pixel_x, 0);
    check("rst_py", pixel_y, 0);
    check("rst_line_end", line_end, 0);
    check("rst_frame_start", frame_start, 0);
    control_reset_n = 1'b1;

    // Line 0 sweep; the h=0 sample also proves v_count restarted at 0.
    for (int h = 0; h < 1328; h++) begin
      tick(h, 1'b1);
      check("sweep_active", video_active, (h < 1024) ? 1 : 0);
      check("sweep_px", pixel_x, (h < 1024) ? h : 0);
      check("sweep_py", pixel_y, 0);
      check("sweep_hsync", hsync, (h >= 1048 && h <= 1183) ? 0 : 1);
      check("sweep_vsync", vsync, 1);
      check("sweep_line_end", line_end, (h == 1327) ? 1 : 0);
      check("sweep_frame_start", frame_start, (h == 0) ? 1 : 0);
    end

    // Walk lines 1..805 and wrap to line 0, visiting h=0 and h=1327 on each line.
    fs_count = 0;
    for (int n = 0; n < 806; n++) begin
      vline = v_model;
      tick(0, 1'b1);
      if (frame_start === 1'b1) fs_count++;
      check("frame_fs", frame_start, (vline == 0) ? 1 : 0);
      check("frame_py", pixel_y, (vline < 768) ? vline : 0);
      check("frame_active", video_active, (vline < 768) ? 1 : 0);
      check("frame_vsync", vsync, exp_vsync(vline));
      tick(1327, 1'b1);
      check("frame_line_end", line_end, 1);
      check("frame_vsync_end", vsync, exp_vsync(vline));
      check("frame_hsync_end", hsync, 1);
    end
    check("frame_fs_count", fs_count, 1);

    // Stall: outputs hold, no repeated line_end, exactly one v advance.
    vline = v_model;
    tick(200, 1'b1);
    check("stall_pre_px", pixel_x, 200);
    for (int i = 0; i < 5; i++) begin
      tick(1327, 1'b0);
      check("stall_active", video_active, 1);
      check("stall_px", pixel_x, 200);
      check("stall_py", pixel_y, vline);
      check("stall_line_end", line_end, 0);
    end
    tick(1327, 1'b1);
    check("stall_le_on", line_end, 1);
    for (int i = 0; i < 5; i++) begin
      tick(1327, 1'b0);
      check("stall_le_hold", line_end, 0);
    end
    tick(0, 1'b1);
    check("stall_v_once", pixel_y, vline + 1);

    // Mid-frame reset at line 400, h=600.
    while (v_model != 400) tick(1327, 1'b1);
    tick(600, 1'b1);
    check("mid_py_pre", pixel_y, 400);
    control_reset_n = 1'b0;
    tick(600, 1'b1);
    check("mid_rst_active", video_active, 0);
    check("mid_rst_py", pixel_y, 0);
    control_reset_n = 1'b1;
    tick(0, 1'b1);
    check("mid_fs", frame_start, 1);
    check("mid_py0", pixel_y, 0);
    tick(300, 1'b1);
    check("mid_px", pixel_x, 300);
    check("mid_py", pixel_y, 0);
    check("mid_fs_once", frame_start, 0);

    // Out-of-range h on line 1.
    tick(1327, 1'b1);
    tick(1100, 1'b1);
    check("oor_pre_hsync", hsync, 0);
    tick(1500, 1'b1);
    check("oor1500_active", video_active, 0);
    check("oor1500_hsync", hsync, 1);
    check("oor1500_le", line_end, 0);
    check("oor1500_fs", frame_start, 0);
    tick(2047, 1'b1);
    check("oor2047_active", video_active, 0);
    check("oor2047_hsync", hsync, 1);
    check("oor2047_le", line_end, 0);
    check("oor2047_fs", frame_start, 0);
    tick(10, 1'b1);
    check("oor_v_held", pixel_y, 1);
    check("oor_fs_none", frame_start, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
